// File: rtl/fifo_pop_arbiter.sv
// fifo_pop_arbiter: round-robin pop arbiter for two registered-flag FIFOs.
// Issues registered pop strobes, forwards read data as a valid-qualified stream.
//
// Ports:
//   clk, reset (async, active-low)
//   empty0/1, almost_empty0/1, error0/1 : registered FIFO status flags
//   q0/q1     : FIFO read data, presented while the matching pop is high
//   pause     : downstream backpressure, blocks new pops
//   pop0/pop1 : registered pop strobes, mutually exclusive
//   data_out, valid_out, class_out : forwarded word, strobe and source class
//   err       : sticky FIFO error indication
//   cnt0/cnt1 : saturating forwarded-word counters per class

module fifo_pop_arbiter #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty0,
    input  logic              almost_empty0,
    input  logic              error0,
    input  logic [DATA_W-1:0] q0,
    input  logic              empty1,
    input  logic              almost_empty1,
    input  logic              error1,
    input  logic [DATA_W-1:0] q1,
    input  logic              pause,
    output logic              pop0,
    output logic              pop1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              class_out,
    output logic              err,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLD,
        ERROR
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   last_nxt;
    logic   pop0_nxt;
    logic   pop1_nxt;
    logic   elig0;
    logic   elig1;
    logic   err_in;
    logic   tag_v;
    logic   tag_c;

    // The flags do not yet account for the pop currently being driven,
    // so a FIFO down to one entry must sit out the cycle after its pop.
    assign elig0  = !empty0 && !(pop0 && almost_empty0);
    assign elig1  = !empty1 && !(pop1 && almost_empty1);
    assign err_in = error0 | error1;

    // First tag stage is the pop register itself; second stage is the
    // valid_out/class_out register.
    assign tag_v = pop0 | pop1;
    assign tag_c = pop1;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        pop0_nxt  = 1'b0;
        pop1_nxt  = 1'b0;
        case (state)
            ERROR: state_nxt = ERROR;
            default: begin
                if (err_in) begin
                    state_nxt = ERROR;
                end else if (pause) begin
                    state_nxt = HOLD;
                end else if (!(elig0 || elig1)) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ACTIVE;
                    if (elig0 && elig1) begin
                        // Both ready: the class that did not win last time
                        pop0_nxt = last;
                        pop1_nxt = !last;
                    end else begin
                        pop0_nxt = elig0;
                        pop1_nxt = elig1;
                    end
                    last_nxt = pop1_nxt;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            pop0      <= 1'b0;
            pop1      <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            class_out <= 1'b0;
            err       <= 1'b0;
            cnt0      <= '0;
            cnt1      <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            pop0      <= pop0_nxt;
            pop1      <= pop1_nxt;
            valid_out <= tag_v;
            if (tag_v) begin
                data_out  <= tag_c ? q1 : q0;
                class_out <= tag_c;
            end
            err <= err | err_in;
            if (valid_out && !class_out && (cnt0 != '1)) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (valid_out && class_out && (cnt1 != '1)) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// tb_fifo_pop_arbiter: scoreboard bench for fifo_pop_arbiter with a
// show-ahead FIFO model per class and a second instance at CNT_W=2.

module tb_fifo_pop_arbiter;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          empty0 = 1'b1;
    logic          ae0 = 1'b0;
    logic          error0 = 1'b0;
    logic [DW-1:0] q0 = '0;
    logic          empty1 = 1'b1;
    logic          ae1 = 1'b0;
    logic          error1 = 1'b0;
    logic [DW-1:0] q1 = '0;
    logic          pause = 1'b0;

    logic          pop0, pop1, valid_out, class_out, err;
    logic [DW-1:0] data_out;
    logic [7:0]    cnt0, cnt1;

    logic          s_pop0, s_pop1, s_valid, s_class, s_err;
    logic [DW-1:0] s_data;
    logic [1:0]    s_cnt0, s_cnt1;

    int vecs = 0;
    int errs = 0;

    logic [DW-1:0] fq0[$];
    logic [DW-1:0] fq1[$];
    logic [DW:0]   exp_q[$];

    always #5 clk = ~clk;

    fifo_pop_arbiter #(.DATA_W(DW), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .empty0(empty0), .almost_empty0(ae0), .error0(error0), .q0(q0),
        .empty1(empty1), .almost_empty1(ae1), .error1(error1), .q1(q1),
        .pause(pause), .pop0(pop0), .pop1(pop1),
        .data_out(data_out), .valid_out(valid_out), .class_out(class_out),
        .err(err), .cnt0(cnt0), .cnt1(cnt1)
    );

    fifo_pop_arbiter #(.DATA_W(DW), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .empty0(empty0), .almost_empty0(ae0), .error0(error0), .q0(q0),
        .empty1(empty1), .almost_empty1(ae1), .error1(error1), .q1(q1),
        .pause(pause), .pop0(s_pop0), .pop1(s_pop1),
        .data_out(s_data), .valid_out(s_valid), .class_out(s_class),
        .err(s_err), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    // FIFO model: flags and head word are registers reflecting the
    // occupancy after this edge's pop.
    always @(posedge clk) begin
        if (pop0) begin
            vecs++;
            if (fq0.size() == 0) begin
                errs++;
                $display("FAIL underflow0: pop0=1 with fifo0 holding 0 words");
            end else begin
                void'(fq0.pop_front());
            end
        end
        if (pop1) begin
            vecs++;
            if (fq1.size() == 0) begin
                errs++;
                $display("FAIL underflow1: pop1=1 with fifo1 holding 0 words");
            end else begin
                void'(fq1.pop_front());
            end
        end
        empty0 <= (fq0.size() == 0);
        ae0    <= (fq0.size() == 1);
        q0     <= (fq0.size() != 0) ? fq0[0] : '0;
        empty1 <= (fq1.size() == 0);
        ae1    <= (fq1.size() == 1);
        q1     <= (fq1.size() != 0) ? fq1[0] : '0;
    end

    // Scoreboard and pop exclusivity monitor
    always @(negedge clk) begin
        logic [DW:0] e;
        if (reset && valid_out) begin
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL sb_extra: got class=%0d data=%0d, expected no word",
                         class_out, data_out);
            end else begin
                e = exp_q.pop_front();
                if ({class_out, data_out} !== e) begin
                    errs++;
                    $display("FAIL sb_word: got class=%0d data=%0d, expected class=%0d data=%0d",
                             class_out, data_out, e[DW], e[DW-1:0]);
                end
            end
        end
        if (reset && (pop0 || pop1)) begin
            vecs++;
            if (pop0 && pop1) begin
                errs++;
                $display("FAIL pop_excl: pop0=%0d pop1=%0d, expected at most one",
                         pop0, pop1);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        pause  = 1'b0;
        error0 = 1'b0;
        error1 = 1'b0;
        fq0.delete();
        fq1.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        repeat (2) step();
        vecs++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL %s_timeout: %0d words outstanding, expected 0",
                     name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) step();
        vecs++;
        if ({pop0, pop1, valid_out, class_out, err, data_out, cnt0, cnt1} !== '0) begin
            errs++;
            $display("FAIL reset_state: pops=%b%b v=%b c=%b err=%b d=%0d cnt=%0d/%0d, expected all 0",
                     pop0, pop1, valid_out, class_out, err, data_out, cnt0, cnt1);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            vecs++;
            if ({pop0, pop1, valid_out, err} !== 4'b0) begin
                errs++;
                $display("FAIL reset_idle: cycle %0d pops=%b%b v=%b err=%b, expected 0",
                         i, pop0, pop1, valid_out, err);
            end
        end
    endtask

    task automatic test_single();
        int npop;
        int nval;
        logic [DW-1:0] w[3];
        w[0] = 4'd3;
        w[1] = 4'd5;
        w[2] = 4'd9;
        npop = 0;
        nval = 0;
        for (int i = 0; i < 3; i++) begin
            fq0.push_back(w[i]);
            exp_q.push_back({1'b0, w[i]});
        end
        for (int i = 0; i < 12; i++) begin
            step();
            npop += int'(pop0);
            nval += int'(valid_out);
            if (i == 1) begin
                vecs++;
                if (pop0 !== 1'b1) begin
                    errs++;
                    $display("FAIL single_latency_pop: pop0=%b, expected 1", pop0);
                end
            end
            if (i == 2) begin
                vecs++;
                if ({valid_out, data_out} !== {1'b1, 4'd3}) begin
                    errs++;
                    $display("FAIL single_latency_out: v=%b d=%0d, expected v=1 d=3",
                             valid_out, data_out);
                end
            end
        end
        vecs++;
        if (npop != 3 || nval != 3) begin
            errs++;
            $display("FAIL single_counts: pops=%0d valids=%0d, expected 3/3", npop, nval);
        end
        vecs++;
        if (cnt0 !== 8'd3 || cnt1 !== 8'd0) begin
            errs++;
            $display("FAIL single_cnt: cnt0=%0d cnt1=%0d, expected 3/0", cnt0, cnt1);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fq0.push_back(DW'(i + 1));
            fq1.push_back(DW'(i + 8));
            exp_q.push_back({1'b0, DW'(i + 1)});
            exp_q.push_back({1'b1, DW'(i + 8)});
        end
        drain("rr");
        vecs++;
        if (cnt0 !== 8'd4 || cnt1 !== 8'd4) begin
            errs++;
            $display("FAIL rr_cnt: cnt0=%0d cnt1=%0d, expected 4/4", cnt0, cnt1);
        end
    endtask

    task automatic test_pause();
        int nval;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fq0.push_back(DW'(i + 2));
            fq1.push_back(DW'(15 - i));
            exp_q.push_back({1'b0, DW'(i + 2)});
            exp_q.push_back({1'b1, DW'(15 - i)});
        end
        repeat (5) step();
        pause = 1'b1;
        nval = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            nval += int'(valid_out);
        end
        vecs++;
        if (nval > 2) begin
            errs++;
            $display("FAIL pause_tail: %0d words after pause, expected at most 2", nval);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            vecs++;
            if ({pop0, pop1, valid_out} !== 3'b0) begin
                errs++;
                $display("FAIL pause_hold: pops=%b%b v=%b, expected 0",
                         pop0, pop1, valid_out);
            end
        end
        pause = 1'b0;
        drain("pause");
        vecs++;
        if (cnt0 !== 8'd6 || cnt1 !== 8'd6) begin
            errs++;
            $display("FAIL pause_cnt: cnt0=%0d cnt1=%0d, expected 6/6", cnt0, cnt1);
        end
    endtask

    task automatic test_error();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fq0.push_back(DW'(i + 1));
            fq1.push_back(DW'(i + 9));
            exp_q.push_back({1'b0, DW'(i + 1)});
            exp_q.push_back({1'b1, DW'(i + 9)});
        end
        repeat (4) step();
        error1 = 1'b1;
        step();
        error1 = 1'b0;
        vecs++;
        if (err !== 1'b1) begin
            errs++;
            $display("FAIL err_set: err=%b, expected 1", err);
        end
        repeat (3) step();
        for (int i = 0; i < 12; i++) begin
            step();
            vecs++;
            if ({pop0, pop1, valid_out, err} !== 4'b0001) begin
                errs++;
                $display("FAIL err_stop: pops=%b%b v=%b err=%b, expected 0 0 0 1",
                         pop0, pop1, valid_out, err);
            end
        end
        do_reset();
        step();
        vecs++;
        if (err !== 1'b0) begin
            errs++;
            $display("FAIL err_clear: err=%b, expected 0", err);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fq0.push_back(DW'(i + 4));
            exp_q.push_back({1'b0, DW'(i + 4)});
        end
        drain("sat");
        vecs++;
        if (s_cnt0 !== 2'd3 || s_cnt1 !== 2'd0) begin
            errs++;
            $display("FAIL sat_cnt: cnt0=%0d cnt1=%0d, expected 3/0", s_cnt0, s_cnt1);
        end
        vecs++;
        if (cnt0 !== 8'd6) begin
            errs++;
            $display("FAIL sat_wide_cnt: cnt0=%0d, expected 6", cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pause();
        test_error();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
